wb_port_arbiter: RTL

Shares the single register-file write port between the in-order pipeline writeback stage and a multi-cycle unit (MDU: mul/div) that completes out of band. The pipeline normally owns the port. MDU results are parked in a small FIFO and drained into idle port cycles. A starvation counter forces a drain by stalling the pipeline for one cycle. The block sits between the WB-data mux / registers_W_en logic and the register file, and also exports a pending-write hit for the hazard unit.

---
 rtl/wb_port_arbiter_if.sv | 41 ++++
 rtl/wb_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// Write-port arbitration bundle: pipeline writeback request, MDU result
// handshake, hazard-unit pending-write query and the register-file write port.
interface wb_port_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          pipe_wb_valid;
   logic          pipe_wb_en;
   logic [AW-1:0] pipe_wb_rd;
   logic [DW-1:0] pipe_wb_data;
   logic          pipe_stall;
   logic          mdu_valid;
   logic [AW-1:0] mdu_rd;
   logic [DW-1:0] mdu_data;
   logic          mdu_ready;
   logic [AW-1:0] query_rs1;
   logic [AW-1:0] query_rs2;
   logic          pend_hit1;
   logic          pend_hit2;
   logic          rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   // Pipeline / MDU / hazard-unit side
   modport master (
      output pipe_wb_valid, pipe_wb_en, pipe_wb_rd, pipe_wb_data,
      output mdu_valid, mdu_rd, mdu_data,
      output query_rs1, query_rs2,
      input  pipe_stall, mdu_ready, pend_hit1, pend_hit2,
      input  rf_we, rf_waddr, rf_wdata
   );

   // Arbiter side
   modport slave (
      input  pipe_wb_valid, pipe_wb_en, pipe_wb_rd, pipe_wb_data,
      input  mdu_valid, mdu_rd, mdu_data,
      input  query_rs1, query_rs2,
      output pipe_stall, mdu_ready, pend_hit1, pend_hit2,
      output rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter. The pipeline owns the port; MDU results
// wait in a small in-order FIFO and drain into idle port cycles. If the FIFO
// head waits STARVE_LIMIT cycles, one FORCE cycle drains it and stalls WB.
module wb_port_arbiter #(
   parameter int DW           = 32,
   parameter int AW           = 5,
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   wb_port_arbiter_if.slave   bus
);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int AGW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGW-1:0] AGE_MAX = AGW'(STARVE_LIMIT);

   typedef enum logic [0:0] {NORMAL = 1'b0, FORCE = 1'b1} state_t;

   state_t        state_r, state_s;
   logic [AW-1:0] rd_mem_r   [DEPTH];
   logic [DW-1:0] data_mem_r [DEPTH];
   logic [DEPTH-1:0] valid_r;
   logic [PW-1:0] wr_ptr_r, rd_ptr_r;
   logic [AGW-1:0] age_r, age_s;
   logic          rf_we_r;
   logic [AW-1:0] rf_waddr_r;
   logic [DW-1:0] rf_wdata_r;

   logic pipe_req_s, fifo_empty_s, fifo_full_s, enq_s, deq_s;
   logic grant_pipe_s, pipe_stall_s;
   logic hit1_s, hit2_s, pipe_waw_s;

   assign pipe_req_s   = bus.pipe_wb_valid & bus.pipe_wb_en & (bus.pipe_wb_rd != '0);
   assign fifo_empty_s = ~|valid_r;
   assign fifo_full_s  = &valid_r;
   // rd=0 results are accepted off the MDU but never stored
   assign enq_s        = bus.mdu_valid & ~fifo_full_s & (bus.mdu_rd != '0);

   // Port arbitration, WB stall, and next age / state
   always_comb begin
      grant_pipe_s = 1'b0;
      deq_s        = 1'b0;
      pipe_stall_s = 1'b0;
      age_s        = age_r;
      state_s      = NORMAL;
      case (state_r)
         NORMAL: begin
            if (pipe_req_s) begin
               grant_pipe_s = 1'b1;
            end else begin
               deq_s = ~fifo_empty_s;
            end
         end
         FORCE: begin
            deq_s        = ~fifo_empty_s;
            pipe_stall_s = bus.pipe_wb_valid;
         end
         default: begin
            deq_s = 1'b0;
         end
      endcase
      // age tracks how long the current head has been passed over
      if (deq_s || fifo_empty_s) begin
         age_s = '0;
      end else if (age_r != AGE_MAX) begin
         age_s = age_r + AGW'(1);
      end else begin
         age_s = age_r;
      end
      if ((age_s == AGE_MAX) && !fifo_empty_s) begin
         state_s = FORCE;
      end else begin
         state_s = NORMAL;
      end
   end

   // Pending-write lookup over stored entries, plus WAW detect for the checker
   always_comb begin
      hit1_s     = 1'b0;
      hit2_s     = 1'b0;
      pipe_waw_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hit1_s     = hit1_s     | (valid_r[i] & (rd_mem_r[i] == bus.query_rs1));
         hit2_s     = hit2_s     | (valid_r[i] & (rd_mem_r[i] == bus.query_rs2));
         pipe_waw_s = pipe_waw_s | (valid_r[i] & (rd_mem_r[i] == bus.pipe_wb_rd));
      end
      hit1_s     = hit1_s & (bus.query_rs1 != '0);
      hit2_s     = hit2_s & (bus.query_rs2 != '0);
      pipe_waw_s = pipe_waw_s & pipe_req_s;
   end

   // FIFO storage, occupancy bits and wrapping pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r  <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_mem_r[i]   <= '0;
            data_mem_r[i] <= '0;
         end
      end else begin
         if (enq_s) begin
            rd_mem_r[wr_ptr_r]   <= bus.mdu_rd;
            data_mem_r[wr_ptr_r] <= bus.mdu_data;
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end
         if (deq_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         // enqueue slot is always free, so it never collides with the head
         for (int i = 0; i < DEPTH; i++) begin
            if (enq_s && (wr_ptr_r == PW'(i))) begin
               valid_r[i] <= 1'b1;
            end else if (deq_s && (rd_ptr_r == PW'(i))) begin
               valid_r[i] <= 1'b0;
            end
         end
      end
   end

   // Arbiter state and head age registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= NORMAL;
         age_r   <= '0;
      end else begin
         state_r <= state_s;
         age_r   <= age_s;
      end
   end

   // Register the granted write onto the register-file port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_r    <= 1'b0;
         rf_waddr_r <= '0;
         rf_wdata_r <= '0;
      end else if (grant_pipe_s) begin
         rf_we_r    <= 1'b1;
         rf_waddr_r <= bus.pipe_wb_rd;
         rf_wdata_r <= bus.pipe_wb_data;
      end else if (deq_s) begin
         rf_we_r    <= 1'b1;
         rf_waddr_r <= rd_mem_r[rd_ptr_r];
         rf_wdata_r <= data_mem_r[rd_ptr_r];
      end else begin
         rf_we_r <= 1'b0;
      end
   end

   assign bus.pipe_stall = pipe_stall_s;
   assign bus.mdu_ready  = ~fifo_full_s;
   assign bus.pend_hit1  = hit1_s;
   assign bus.pend_hit2  = hit2_s;
   assign bus.rf_we      = rf_we_r;
   assign bus.rf_waddr   = rf_waddr_r;
   assign bus.rf_wdata   = rf_wdata_r;

   wb_port_arbiter_chk #(.AW(AW)) u_chk (
      .clk          (clk),
      .rst_n        (rst_n),
      .pipe_waw     (pipe_waw_s),
      .rf_we        (rf_we_r),
      .rf_waddr     (rf_waddr_r),
      .pipe_stall   (pipe_stall_s),
      .force_active (state_r == FORCE)
   );
endmodule

// Protocol checks for the arbiter
module wb_port_arbiter_chk #(
   parameter int AW = 5
) (
   input logic          clk,
   input logic          rst_n,
   input logic          pipe_waw,
   input logic          rf_we,
   input logic [AW-1:0] rf_waddr,
   input logic          pipe_stall,
   input logic          force_active
);
   // Pipeline must never write an rd that still has a parked MDU result
   a_no_waw: assert property (@(posedge clk) disable iff (!rst_n) !pipe_waw);
   // x0 never reaches the register file
   a_rf_addr_nz: assert property (@(posedge clk) disable iff (!rst_n) rf_we |-> (rf_waddr != '0));
   // WB is only ever stalled by a forced drain
   a_stall_force: assert property (@(posedge clk) disable iff (!rst_n) pipe_stall |-> force_active);
endmodule
